vga_plot_scheduler: RTL
=======================

Name: vga_plot_scheduler

Overview:
- Shares the single VGA pixel-write port (x, y, color, plot) between NREQ drawing engines.
- Round-robin arbitration; accepts at most one pixel per cycle.
- Contains a built-in clear-screen sequencer that takes the port and sweeps every pixel to a fixed color.
- Sits between the drawing engines and the top-level VGA_X/VGA_Y/VGA_COLOR/plot outputs.

Parameters:
- NREQ, 3, number of requesters (2..4).
- XW, 8, x coordinate width (8/9/10 for 160/320/640 modes).
- YW, 7, y coordinate width (XW-1).
- XMAX, 160, screen width in pixels.
- YMAX, 120, screen height in pixels.
- CW, 3, color width.
- CLEAR_COLOR, 3'b000, color written by the clear sweep.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester pixel request.
- req_x  in  NREQ*XW  packed x; requester i at [i*XW +: XW].
- req_y  in  NREQ*YW  packed y.
- req_color  in  NREQ*CW  packed color.
- req_ready  out  NREQ  one-hot; pixel of requester i accepted this cycle.
- clear  in  1  single-cycle pulse; starts a full-screen clear.
- busy_clear  out  1  high while the clear sweep runs.
- VGA_X  out  XW  registered pixel x.
- VGA_Y  out  YW  registered pixel y.
- VGA_COLOR  out  CW  registered pixel color.
- plot  out  1  registered write strobe.

Behaviour:
- Reset (synchronous, active-high): VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, req_ready=0, busy_clear=0, state=IDLE, rr_ptr=0, clear counters=0.
- Handshake:
  - A transfer occurs on a cycle where req_valid[i]=1 and req_ready[i]=1.
  - req_ready is combinational from req_valid, rr_ptr and state.
  - A requester must hold x/y/color stable while valid and not ready.
- States:
  - IDLE (arbitrate).
  - CLEAR (sweep).
- IDLE:
  - Grant goes to the first asserted req_valid found searching from rr_ptr upward, modulo NREQ.
  - After a grant to index g, rr_ptr <= (g+1) mod NREQ. rr_ptr is unchanged when nothing is granted.
  - Next cycle: VGA_X/Y/COLOR <= granted pixel, plot <= 1. With no grant, plot <= 0 and the coordinate registers hold.
  - Latency from accept to plot is exactly 1 cycle.
  - Throughput is 1 pixel/cycle; a single requester held valid is granted every cycle.
- clear in IDLE:
  - The request is registered as pending.
  - Transition to CLEAR happens on the next edge.
  - Any arbitration on the same cycle still completes.
- CLEAR:
  - req_ready=0 and busy_clear=1.
  - cx/cy start at 0 and scan row-major: cx increments; at cx=XMAX-1, cx wraps to 0 and cy increments.
  - Each cycle: plot=1, VGA_COLOR=CLEAR_COLOR, VGA_X=cx, VGA_Y=cy, registered with the same 1-cycle latency.
  - After the pixel (XMAX-1, YMAX-1) is issued, return to IDLE.
  - busy_clear deasserts the cycle after the last clear pixel is registered.
  - The sweep takes exactly XMAX*YMAX cycles.
- clear asserted during CLEAR: ignored (no restart).
- Reset during CLEAR: aborts immediately to the reset state; the partial sweep is not resumed.
- Widths:
  - Counters are XW/YW wide.
  - XMAX-1 and YMAX-1 compare at full width, with no overflow beyond the screen.
- Requests arriving during CLEAR stay pending on req_valid. Arbitration resumes from the saved rr_ptr.

Optional Feature:
- Macro: VGA_PLOT_CLIP_EN.
- Defined:
  - A granted pixel with x>=XMAX or y>=YMAX is accepted (req_ready=1, rr_ptr advances) but produces plot=0 next cycle.
  - A 16-bit saturating output clip_count (extra port) counts these pixels; it resets to 0.
- Undefined:
  - No clip check; every granted pixel plots with x/y truncated to XW/YW.
  - No clip_count port.

Decomposition:
- Package vga_plot_pkg: state enum (IDLE, CLEAR), per-resolution XW/YW/XMAX/YMAX constants selected by the resolution macros, and the CLEAR_COLOR default.
- Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs a one-hot gnt and the index. Purely combinational, instantiated once.

Test Plan:
- Reset, then req_valid=3'b111 held with distinct pixels → grants in order 0,1,2,0,…, one per cycle; plot=1 each cycle one cycle after each grant, with the matching x/y/color.
- Only requester 2 valid, (x=5, y=7, color=3'b110) → req_ready=3'b100 the same cycle; next cycle VGA_X=5, VGA_Y=7, VGA_COLOR=6, plot=1.
- clear pulse with defaults → busy_clear high for 19200 cycles; plot=1 with color 0 on every pixel, first (0,0), last (159,119); req_ready=0 throughout.
- During a clear, req_valid[1]=1 and a second clear pulse → no restart (total still 19200 cycles); requester 1 granted the first IDLE cycle.
- Reset asserted mid-clear at pixel (40,10) → next cycle plot=0, busy_clear=0, all outputs 0; a following clear starts again from (0,0).
- With VGA_PLOT_CLIP_EN, request x=160, y=3 → req_ready=1, plot=0 next cycle, clip_count increments to 1.

Source files
------------

// File: rtl/vga_plot_pkg.sv
// Shared types and default screen geometry for the VGA plot scheduler.
// The resolution macros VGA_RES_640 / VGA_RES_320 pick the default geometry
// (160x120 when neither is defined).
package vga_plot_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

`ifdef VGA_RES_640
  localparam int DEF_XW   = 10;
  localparam int DEF_YW   = 9;
  localparam int DEF_XMAX = 640;
  localparam int DEF_YMAX = 480;
`elsif VGA_RES_320
  localparam int DEF_XW   = 9;
  localparam int DEF_YW   = 8;
  localparam int DEF_XMAX = 320;
  localparam int DEF_YMAX = 240;
`else
  localparam int DEF_XW   = 8;
  localparam int DEF_YW   = 7;
  localparam int DEF_XMAX = 160;
  localparam int DEF_YMAX = 120;
`endif

  localparam int DEF_CW          = 3;
  localparam int DEF_CLEAR_COLOR = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found when
// searching upward from ptr (wrapping modulo NREQ) wins.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic [PW:0]   cand;

  // Scan the requesters in rotated order and latch the first hit.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        idx   = cand[PW-1:0];
      end
    end
    if (found) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vga_plot_scheduler.sv
// Shares one registered VGA pixel-write port between NREQ drawing engines
// with round-robin arbitration, and owns a full-screen clear sweep.
// Optional feature macro: VGA_PLOT_CLIP_EN (drop off-screen pixels and
// count them on clip_count).
module vga_plot_scheduler
  import vga_plot_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW,
  parameter int XMAX = DEF_XMAX,
  parameter int YMAX = DEF_YMAX,
  parameter int CW   = DEF_CW,
  parameter logic [CW-1:0] CLEAR_COLOR = CW'(DEF_CLEAR_COLOR)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*YW-1:0] req_y,
  input  logic [NREQ*CW-1:0] req_color,
  output logic [NREQ-1:0]  req_ready,
  input  logic             clear,
  output logic             busy_clear,
  output logic [XW-1:0]    VGA_X,
  output logic [YW-1:0]    VGA_Y,
  output logic [CW-1:0]    VGA_COLOR,
  output logic             plot
`ifdef VGA_PLOT_CLIP_EN
  ,
  output logic [15:0]      clip_count
`endif
);

  localparam int PW = $clog2(NREQ);

  state_e        state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] c_q, c_d;
  logic          plot_q, plot_d;
`ifdef VGA_PLOT_CLIP_EN
  logic [15:0]   clip_q, clip_d;
  logic          off_screen;
`endif

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic [XW-1:0]   rx [NREQ];
  logic [YW-1:0]   ry [NREQ];
  logic [CW-1:0]   rc [NREQ];

  // Unpack the per-requester pixel fields into indexable arrays.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign rx[gi] = req_x[gi*XW +: XW];
    assign ry[gi] = req_y[gi*YW +: YW];
    assign rc[gi] = req_color[gi*CW +: CW];
  end

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

`ifdef VGA_PLOT_CLIP_EN
  assign off_screen = ({1'b0, rx[gnt_idx]} >= (XW+1)'(XMAX)) ||
                      ({1'b0, ry[gnt_idx]} >= (YW+1)'(YMAX));
`endif

  // Next-state: arbitration in IDLE, row-major pixel sweep in CLEAR.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    x_d        = x_q;
    y_d        = y_q;
    c_d        = c_q;
    plot_d     = 1'b0;
    req_ready  = '0;
    busy_clear = (state_q == CLEAR);
`ifdef VGA_PLOT_CLIP_EN
    clip_d     = clip_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          rr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`ifdef VGA_PLOT_CLIP_EN
          if (off_screen) begin
            if (clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
          end else begin
            x_d    = rx[gnt_idx];
            y_d    = ry[gnt_idx];
            c_d    = rc[gnt_idx];
            plot_d = 1'b1;
          end
`else
          x_d    = rx[gnt_idx];
          y_d    = ry[gnt_idx];
          c_d    = rc[gnt_idx];
          plot_d = 1'b1;
`endif
        end
        // A clear request still lets this cycle's grant complete.
        if (clear) begin
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      CLEAR: begin
        x_d    = cx_q;
        y_d    = cy_q;
        c_d    = CLEAR_COLOR;
        plot_d = 1'b1;
        if (cx_q == XW'(XMAX-1)) begin
          cx_d = '0;
          if (cy_q == YW'(YMAX-1)) begin
            cy_d    = '0;
            state_d = IDLE;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
`ifdef VGA_PLOT_CLIP_EN
      clip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
`ifdef VGA_PLOT_CLIP_EN
      clip_q  <= clip_d;
`endif
    end
  end

  assign VGA_X     = x_q;
  assign VGA_Y     = y_q;
  assign VGA_COLOR = c_q;
  assign plot      = plot_q;
`ifdef VGA_PLOT_CLIP_EN
  assign clip_count = clip_q;
`endif

endmodule
